// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
// Shared types and constants for the two-master Wishbone arbiter.
//   arb_state_t : arbiter FSM state encoding
//   M_IF, M_MEM : master index into the packed m_* vectors
//   TMO_W       : width of the bus-timeout counter
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } arb_state_t;

    localparam int M_IF  = 0;
    localparam int M_MEM = 1;

    localparam int TMO_W = 8;

endpackage

// File: rtl/wb_arb_timeout.sv
// wb_arb_timeout
// Saturating bus-timeout counter. Cleared when a new owner takes the bus,
// counts busy cycles that pass without an acknowledge, and flags expiry
// while the count sits at TIMEOUT. TIMEOUT = 0 disables expiry.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : restart the count (new grant this cycle)
//   inc        : count this cycle (busy, no ack)
//   active     : bus is currently owned; expiry only reported while set
//   expired    : count has reached TIMEOUT in an active cycle
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    input  logic active,
    output logic expired
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] SAT   = '1;

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != SAT)) begin
            cnt_q <= cnt_q + TMO_W'(1);
        end
    end

    assign expired = active && (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter
// Shares one classic Wishbone slave port between the instruction-fetch
// master (index 0) and the data-memory master (index 1). MEM wins ties,
// except that IF is forced through after STARVE_LIMIT consecutive MEM
// grants made while IF was waiting. A transfer that sees no ack for
// TIMEOUT busy cycles is terminated with a one-cycle error to its owner.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   m_cyc_i/m_stb_i/...  : packed master request buses, [0]=IF, [1]=MEM
//   m_ack_o, m_err_o     : per-master ack / timeout error
//   m_dat_o              : slave read data, shared by both masters
//   s_*                  : single Wishbone master port toward the slaves
//   grant_o              : one-hot current owner, 00 when idle
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | no owner; slave port quiet, arbitrating requests
// BUSY_IF  | IF owns the slave port until ack, abort or timeout
// BUSY_MEM | MEM owns the slave port until ack, abort or timeout
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int          STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    m_cyc_i,
    input  logic [1:0]                    m_stb_i,
    input  logic [1:0]                    m_we_i,
    input  logic [2*ADDR_WIDTH-1:0]       m_adr_i,
    input  logic [2*DATA_WIDTH-1:0]       m_dat_i,
    input  logic [2*(DATA_WIDTH/8)-1:0]   m_sel_i,
    output logic [1:0]                    m_ack_o,
    output logic [1:0]                    m_err_o,
    output logic [DATA_WIDTH-1:0]         m_dat_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic                          s_we_o,
    output logic [ADDR_WIDTH-1:0]         s_adr_o,
    output logic [DATA_WIDTH-1:0]         s_dat_o,
    output logic [DATA_WIDTH/8-1:0]       s_sel_o,
    input  logic                          s_ack_i,
    input  logic [DATA_WIDTH-1:0]         s_dat_i,
    output logic [1:0]                    grant_o
);

    localparam int SEL_W    = DATA_WIDTH / 8;
    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state_q, state_d;
    logic [1:0]          req;
    logic [STARVE_W-1:0] starve_q;
    logic                busy;
    logic                own_mem;
    logic                tmo_expired;
    logic                tmo_clr;
    logic                tmo_inc;
    logic                err_now;
    logic                if_grant;
    logic                mem_grant;

    assign req     = m_cyc_i & m_stb_i;
    assign busy    = (state_q != IDLE);
    assign own_mem = (state_q == BUSY_MEM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ack is checked first in each busy state so that an ack landing on the
    // expiry cycle completes normally. On completion the finishing master is
    // never re-granted; the bus goes straight to the other one if it waits.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if ((starve_q == STARVE_MAX) && req[M_IF]) begin
                    state_d = BUSY_IF;
                end else if (req[M_MEM]) begin
                    state_d = BUSY_MEM;
                end else if (req[M_IF]) begin
                    state_d = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (s_ack_i) begin
                    state_d = req[M_MEM] ? BUSY_MEM : IDLE;
                end else if (!m_cyc_i[M_IF] || tmo_expired) begin
                    state_d = IDLE;
                end
            end
            BUSY_MEM: begin
                if (s_ack_i) begin
                    state_d = req[M_IF] ? BUSY_IF : IDLE;
                end else if (!m_cyc_i[M_MEM] || tmo_expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_grant  = (state_d == BUSY_IF)  && (state_q != BUSY_IF);
    assign mem_grant = (state_d == BUSY_MEM) && (state_q != BUSY_MEM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else if (if_grant) begin
            starve_q <= '0;
        end else if (mem_grant && req[M_IF] && (starve_q != STARVE_MAX)) begin
            starve_q <= starve_q + STARVE_W'(1);
        end
    end

    assign tmo_clr = if_grant || mem_grant;
    assign tmo_inc = busy && !s_ack_i;

    wb_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmo_clr),
        .inc     (tmo_inc),
        .active  (busy),
        .expired (tmo_expired)
    );

    assign err_now = tmo_expired && !s_ack_i;

    // Data-path muxes default to master 0 while idle; control is gated off.
    assign s_adr_o = own_mem ? m_adr_i[M_MEM*ADDR_WIDTH +: ADDR_WIDTH]
                             : m_adr_i[M_IF*ADDR_WIDTH  +: ADDR_WIDTH];
    assign s_dat_o = own_mem ? m_dat_i[M_MEM*DATA_WIDTH +: DATA_WIDTH]
                             : m_dat_i[M_IF*DATA_WIDTH  +: DATA_WIDTH];
    assign s_sel_o = own_mem ? m_sel_i[M_MEM*SEL_W +: SEL_W]
                             : m_sel_i[M_IF*SEL_W  +: SEL_W];

    // The slave port is dropped in the expiry cycle so the stuck slave sees
    // the cycle end together with the error to the master.
    assign s_cyc_o = busy && !err_now && (own_mem ? m_cyc_i[M_MEM] : m_cyc_i[M_IF]);
    assign s_stb_o = busy && !err_now && (own_mem ? m_stb_i[M_MEM] : m_stb_i[M_IF]);
    assign s_we_o  = busy && (own_mem ? m_we_i[M_MEM] : m_we_i[M_IF]);

    assign grant_o = {(state_q == BUSY_MEM), (state_q == BUSY_IF)};
    assign m_ack_o = grant_o & {2{s_ack_i}};
    assign m_err_o = grant_o & {2{err_now}};
    assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter
// Directed bench for wb_bus_arbiter with STARVE_LIMIT = 4 and TIMEOUT = 8.
// Inputs change 1 ns after the rising edge, outputs are checked 1 ns later.
module tb_wb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      m_cyc_i, m_stb_i, m_we_i;
    logic [2*AW-1:0] m_adr_i;
    logic [2*DW-1:0] m_dat_i;
    logic [2*SW-1:0] m_sel_i;
    logic [1:0]      m_ack_o, m_err_o;
    logic [DW-1:0]   m_dat_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic            s_ack_i;
    logic [DW-1:0]   s_dat_i;
    logic [1:0]      grant_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (4),
        .TIMEOUT      (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_ack_i (s_ack_i),
        .s_dat_i (s_dat_i),
        .grant_o (grant_o)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_if(input logic req, input logic we, input logic [AW-1:0] adr);
        m_cyc_i[0]       = req;
        m_stb_i[0]       = req;
        m_we_i[0]        = we;
        m_adr_i[AW-1:0]  = adr;
        m_dat_i[DW-1:0]  = 32'h1F1F_0000;
        m_sel_i[SW-1:0]  = 4'hF;
    endtask

    task automatic set_mem(input logic req, input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        m_cyc_i[1]          = req;
        m_stb_i[1]          = req;
        m_we_i[1]           = we;
        m_adr_i[2*AW-1:AW]  = adr;
        m_dat_i[2*DW-1:DW]  = dat;
        m_sel_i[2*SW-1:SW]  = sel;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        m_adr_i = {32'h2222_0000, 32'h1111_0000};
        m_dat_i = '0;
        m_sel_i = '0;
        s_ack_i = 1'b0;
        s_dat_i = '0;
        #2;
        check_val("rst_grant", grant_o, 2'b00);
        check_val("rst_s_ctl", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
        check_val("rst_ack_err", {m_ack_o, m_err_o}, 4'h0);
        check_val("rst_adr_m0", s_adr_o, 32'h1111_0000);
        tick();
        reset = 1'b0;

        // ack while idle is ignored
        s_ack_i = 1'b1;
        #1;
        check_val("idle_ack", m_ack_o, 2'b00);
        tick();
        check_val("idle_ack_state", grant_o, 2'b00);
        s_ack_i = 1'b0;

        // IF-only read, slave acks two cycles after strobe
        set_if(1'b1, 1'b0, 32'h8000_0000);
        s_dat_i = 32'hDEAD_BEEF;
        #1;
        check_val("if_lat_grant", grant_o, 2'b00);
        check_val("if_lat_stb", s_stb_o, 1'b0);
        tick();
        check_val("if_grant", grant_o, 2'b01);
        check_val("if_stb", {s_cyc_o, s_stb_o}, 2'b11);
        check_val("if_adr", s_adr_o, 32'h8000_0000);
        check_val("if_we", s_we_o, 1'b0);
        check_val("if_noack0", m_ack_o, 2'b00);
        tick();
        check_val("if_noack1", m_ack_o, 2'b00);
        tick();
        s_ack_i = 1'b1;
        #1;
        check_val("if_ack", m_ack_o, 2'b01);
        check_val("if_rdata", m_dat_o, 32'hDEAD_BEEF);
        tick();
        s_ack_i = 1'b0;
        set_if(1'b0, 1'b0, 32'h0);
        #1;
        check_val("if_done_grant", grant_o, 2'b00);
        check_val("if_done_ack", m_ack_o, 2'b00);

        // simultaneous requests: MEM first, direct handoff to IF
        set_if(1'b1, 1'b0, 32'h0000_1000);
        set_mem(1'b1, 1'b1, 32'h0000_2000, 32'h0000_55AA, 4'h3);
        #1;
        check_val("sim_idle", grant_o, 2'b00);
        tick();
        check_val("sim_mem_grant", grant_o, 2'b10);
        check_val("sim_mem_adr", s_adr_o, 32'h0000_2000);
        check_val("sim_mem_we", s_we_o, 1'b1);
        check_val("sim_mem_dat", s_dat_o, 32'h0000_55AA);
        check_val("sim_mem_sel", s_sel_o, 4'h3);
        s_ack_i = 1'b1;
        #1;
        check_val("sim_mem_ack", m_ack_o, 2'b10);
        tick();
        s_ack_i = 1'b0;
        set_mem(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check_val("sim_handoff", grant_o, 2'b01);
        check_val("sim_if_stb", s_stb_o, 1'b1);
        check_val("sim_if_adr", s_adr_o, 32'h0000_1000);
        check_val("sim_if_sel", s_sel_o, 4'hF);
        s_ack_i = 1'b1;
        #1;
        check_val("sim_if_ack", m_ack_o, 2'b01);
        tick();
        s_ack_i = 1'b0;
        set_if(1'b0, 1'b0, 32'h0);
        #1;
        check_val("sim_done", grant_o, 2'b00);

        // starvation: IF waits through four MEM grants, then wins
        set_mem(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF);
        for (int j = 0; j < 4; j++) begin
            set_if(1'b1, 1'b0, 32'h0000_3000);
            s_ack_i = 1'b0;
            #1;
            check_val("stv_idle", grant_o, 2'b00);
            tick();
            s_ack_i    = 1'b1;
            m_stb_i[0] = 1'b0;
            #1;
            check_val("stv_mem", grant_o, 2'b10);
            check_val("stv_mem_ack", m_ack_o, 2'b10);
            tick();
        end
        set_if(1'b1, 1'b0, 32'h0000_3000);
        s_ack_i = 1'b0;
        #1;
        check_val("stv_idle5", grant_o, 2'b00);
        tick();
        check_val("stv_if_wins", grant_o, 2'b01);
        check_val("stv_if_adr", s_adr_o, 32'h0000_3000);
        s_ack_i = 1'b1;
        #1;
        check_val("stv_if_ack", m_ack_o, 2'b01);
        tick();
        s_ack_i = 1'b0;
        set_if(1'b0, 1'b0, 32'h0);
        #1;
        check_val("stv_mem5", grant_o, 2'b10);
        s_ack_i = 1'b1;
        #1;
        check_val("stv_mem5_ack", m_ack_o, 2'b10);
        tick();
        s_ack_i = 1'b0;
        set_mem(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check_val("stv_done", grant_o, 2'b00);

        // timeout: IF write never acked
        set_if(1'b1, 1'b1, 32'h0000_6000);
        tick();
        for (int k = 0; k < 8; k++) begin
            check_val("tmo_wait_err", m_err_o, 2'b00);
            check_val("tmo_wait_cyc", s_cyc_o, 1'b1);
            tick();
        end
        check_val("tmo_err", m_err_o, 2'b01);
        check_val("tmo_cyc_low", {s_cyc_o, s_stb_o}, 2'b00);
        check_val("tmo_err_grant", grant_o, 2'b01);
        set_if(1'b0, 1'b0, 32'h0);
        set_mem(1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'hF);
        tick();
        check_val("tmo_idle", grant_o, 2'b00);
        check_val("tmo_err_gone", m_err_o, 2'b00);
        tick();
        check_val("tmo_next_mem", grant_o, 2'b10);

        // ack arriving in the expiry cycle wins over the error
        for (int k = 0; k < 8; k++) begin
            check_val("avt_wait_err", m_err_o, 2'b00);
            tick();
        end
        s_ack_i = 1'b1;
        #1;
        check_val("avt_ack", m_ack_o, 2'b10);
        check_val("avt_err", m_err_o, 2'b00);
        check_val("avt_cyc", s_cyc_o, 1'b1);
        tick();
        s_ack_i = 1'b0;
        set_mem(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check_val("avt_done", grant_o, 2'b00);

        // asynchronous reset in the middle of a transfer
        set_if(1'b1, 1'b0, 32'h0000_8000);
        tick();
        check_val("rmt_cyc_pre", s_cyc_o, 1'b1);
        s_ack_i = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_val("rmt_cyc", s_cyc_o, 1'b0);
        check_val("rmt_grant", grant_o, 2'b00);
        check_val("rmt_ack", m_ack_o, 2'b00);
        check_val("rmt_err", m_err_o, 2'b00);
        set_if(1'b0, 1'b0, 32'h0);
        s_ack_i = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        check_val("rmt_idle0", grant_o, 2'b00);
        tick();
        check_val("rmt_idle1", grant_o, 2'b00);
        check_val("rmt_idle_cyc", s_cyc_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
